// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: frame-buffer SRAM arbiter, display > posted write > host read, one SRAM op per clk.
// Rev 1.0 -- optional starvation counter compiled in with FB_STARVE_MON_EN.
`default_nettype none

module fb_access_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_rvalid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  input  logic [DATA_W-1:0] i_sram_dq
`ifdef FB_STARVE_MON_EN
  ,
  output logic [15:0]       o_starve_cnt
`endif
);

  localparam int             PTR_W    = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_DISP = 2'd1,
    OP_WR   = 2'd2,
    OP_HRD  = 2'd3
  } op_t;

  op_t op_state, op_next;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full, fifo_empty, push, pop;

  logic              rd_outstanding, rd_pending, rd_accept;
  logic [ADDR_W-1:0] rd_addr_q, slot_addr;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = i_wr_valid && !fifo_full;
  assign pop        = (op_next == OP_WR);
  assign rd_accept  = i_rd_valid && !rd_outstanding;
  assign o_wr_ready = !fifo_full;
  assign o_rd_ready = !rd_outstanding;

  // Host reads wait for an empty FIFO so they always observe earlier posted writes.
  always_comb begin
    op_next   = OP_IDLE;
    slot_addr = o_sram_addr;
    if (i_disp_req) begin
      op_next   = OP_DISP;
      slot_addr = i_disp_addr;
    end else if (!fifo_empty) begin
      op_next   = OP_WR;
      slot_addr = fifo_addr[rd_ptr];
    end else if (rd_pending) begin
      op_next   = OP_HRD;
      slot_addr = rd_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_state <= OP_IDLE;
    else        op_state <= op_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_addr;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // pending: accepted but not yet granted; outstanding: until the data pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_outstanding <= 1'b0;
      rd_pending     <= 1'b0;
      rd_addr_q      <= '0;
    end else begin
      if (rd_accept) begin
        rd_addr_q      <= i_rd_addr;
        rd_pending     <= 1'b1;
        rd_outstanding <= 1'b1;
      end
      if (op_next == OP_HRD) rd_pending <= 1'b0;
      if (op_state == OP_HRD) rd_outstanding <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
    end else begin
      o_sram_addr  <= slot_addr;
      o_sram_we_n  <= (op_next != OP_WR);
      o_sram_dq_oe <= (op_next == OP_WR);
      o_sram_oe_n  <= !((op_next == OP_DISP) || (op_next == OP_HRD));
      if (op_next == OP_WR) o_sram_dq <= fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_disp_valid <= 1'b0;
      o_disp_data  <= '0;
      o_rd_rvalid  <= 1'b0;
      o_rd_data    <= '0;
    end else begin
      o_disp_valid <= (op_state == OP_DISP);
      o_rd_rvalid  <= (op_state == OP_HRD);
      if (op_state == OP_DISP) o_disp_data <= i_sram_dq;
      if (op_state == OP_HRD)  o_rd_data   <= i_sram_dq;
    end
  end

`ifdef FB_STARVE_MON_EN
  // A read counts as starved while it is waiting for a slot, not while in flight.
  logic starve_evt;
  assign starve_evt = (fifo_full && i_wr_valid) || (rd_pending && (op_next != OP_HRD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       o_starve_cnt <= '0;
    else if (starve_evt && (o_starve_cnt != 16'hFFFF)) o_starve_cnt <= o_starve_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: directed vector table plus hand sequences for fb_access_arbiter.
// Rev 1.0 -- small behavioural SRAM model on the pins.
`default_nettype none

module tb_fb_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [19:0] disp_addr = '0;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        wr_valid = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_valid = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_rvalid;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;
  logic [15:0] sram_rd;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  fb_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WFIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_data(disp_data), .o_disp_valid(disp_valid),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
    .o_rd_data(rd_data), .o_rd_rvalid(rd_rvalid),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq), .o_sram_dq_oe(sram_dq_oe),
    .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n), .i_sram_dq(sram_rd)
  );

  // SRAM model: unwritten words return a fixed pattern, 0x010 preloaded with 0xABCD
  logic [15:0] mem   [4096];
  bit          wrote [4096];

  function automatic logic [15:0] base(input logic [11:0] a);
    return (a == 12'h010) ? 16'hABCD : ({4'h0, a} ^ 16'h5A5A);
  endfunction

  always_comb begin
    sram_rd = 16'h0000;
    if (!sram_oe_n)
      sram_rd = wrote[sram_addr[11:0]] ? mem[sram_addr[11:0]] : base(sram_addr[11:0]);
  end

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[11:0]]   <= sram_dq;
      wrote[sram_addr[11:0]] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        disp_req;
    logic [19:0] disp_addr;
    logic        wr_valid;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic [19:0] rd_addr;
    logic        e_we_n, e_oe_n, e_dq_oe;
    logic [19:0] e_addr;
    logic [15:0] e_dq;
    logic        e_dv;
    logic [15:0] e_ddata;
    logic        e_wr_ready, e_rd_ready, e_rv;
    logic [15:0] e_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  int wr_sent, bad_we, bad_dv, we_cnt, first_we, last_we, bad_wd, pop_idx, bad_rst;

  initial begin
    // disp  daddr  wr wadr   wdata    rd radr  | we oe dqoe addr     dq       dv ddata    wrdy rrdy rv rdata
    vec[0]  = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 1, 0, 20'h00000, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};
    vec[1]  = '{1, 20'h010, 0, 20'h0,   16'h0,    0, 20'h0,   1, 1, 0, 20'h00000, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};
    vec[2]  = '{1, 20'h020, 0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00010, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};
    vec[3]  = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00020, 16'h0,    1, 16'hABCD, 1, 1, 0, 16'h0};
    vec[4]  = '{0, 20'h0,   1, 20'h100, 16'h1234, 0, 20'h0,   1, 1, 0, 20'h00020, 16'h0,    1, 16'h5A7A, 1, 1, 0, 16'h0};
    vec[5]  = '{0, 20'h0,   0, 20'h0,   16'h0,    1, 20'h100, 1, 1, 0, 20'h00020, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};
    vec[6]  = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   0, 1, 1, 20'h00100, 16'h1234, 0, 16'h0,    1, 0, 0, 16'h0};
    vec[7]  = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00100, 16'h0,    0, 16'h0,    1, 0, 0, 16'h0};
    vec[8]  = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 1, 0, 20'h00100, 16'h0,    0, 16'h0,    1, 1, 1, 16'h1234};
    vec[9]  = '{1, 20'h030, 0, 20'h0,   16'h0,    1, 20'h040, 1, 1, 0, 20'h00100, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};
    vec[10] = '{1, 20'h031, 0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00030, 16'h0,    0, 16'h0,    1, 0, 0, 16'h0};
    vec[11] = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00031, 16'h0,    1, 16'h5A6A, 1, 0, 0, 16'h0};
    vec[12] = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 0, 0, 20'h00040, 16'h0,    1, 16'h5A6B, 1, 0, 0, 16'h0};
    vec[13] = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 1, 0, 20'h00040, 16'h0,    0, 16'h0,    1, 1, 1, 16'h5A1A};
    vec[14] = '{0, 20'h0,   0, 20'h0,   16'h0,    0, 20'h0,   1, 1, 0, 20'h00040, 16'h0,    0, 16'h0,    1, 1, 0, 16'h0};

    // reset values, then 10 quiet cycles after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    bad_rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!sram_we_n || !sram_oe_n || sram_dq_oe || disp_valid || rd_rvalid || !wr_ready || !rd_ready)
        bad_rst++;
      tick();
    end
    chk("idle_after_reset", bad_rst, 0);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      disp_req  = vec[i].disp_req;  disp_addr = vec[i].disp_addr;
      wr_valid  = vec[i].wr_valid;  wr_addr   = vec[i].wr_addr;  wr_data = vec[i].wr_data;
      rd_valid  = vec[i].rd_valid;  rd_addr   = vec[i].rd_addr;
      @(negedge clk);
      chk($sformatf("v%0d we_n", i),     sram_we_n,  vec[i].e_we_n);
      chk($sformatf("v%0d oe_n", i),     sram_oe_n,  vec[i].e_oe_n);
      chk($sformatf("v%0d dq_oe", i),    sram_dq_oe, vec[i].e_dq_oe);
      chk($sformatf("v%0d addr", i),     sram_addr,  vec[i].e_addr);
      if (vec[i].e_dq_oe) chk($sformatf("v%0d dq", i), sram_dq, vec[i].e_dq);
      chk($sformatf("v%0d disp_valid", i), disp_valid, vec[i].e_dv);
      if (vec[i].e_dv) chk($sformatf("v%0d disp_data", i), disp_data, vec[i].e_ddata);
      chk($sformatf("v%0d wr_ready", i), wr_ready,   vec[i].e_wr_ready);
      chk($sformatf("v%0d rd_ready", i), rd_ready,   vec[i].e_rd_ready);
      chk($sformatf("v%0d rd_rvalid", i), rd_rvalid, vec[i].e_rv);
      if (vec[i].e_rv) chk($sformatf("v%0d rd_data", i), rd_data, vec[i].e_rdata);
      tick();
    end
    disp_req = 0; wr_valid = 0; rd_valid = 0;

    // active line: 640 display fetches starve 6 offered writes
    wr_sent = 0; bad_we = 0; bad_dv = 0;
    for (int i = 0; i < 640; i++) begin
      disp_req  = 1'b1;
      disp_addr = 20'(32'h400 + i);
      wr_valid  = (wr_sent < 6);
      wr_addr   = 20'(32'h200 + wr_sent);
      wr_data   = 16'(32'hC000 + wr_sent);
      @(negedge clk);
      if (!sram_we_n) bad_we++;
      if (i >= 2 && (!disp_valid || disp_data !== base(12'(32'h400 + i - 2)))) bad_dv++;
      if (i == 639) chk("wr_ready_full", wr_ready, 0);
      if (wr_valid && wr_ready) wr_sent++;
      tick();
    end
    chk("active_no_write", bad_we, 0);
    chk("active_disp_stream", bad_dv, 0);
    chk("fifo_fill_count", wr_sent, 4);

    // blanking: FIFO drains back-to-back and the last two writes get in
    disp_req = 1'b0;
    we_cnt = 0; first_we = -1; last_we = -1; bad_wd = 0; pop_idx = 0;
    for (int j = 0; j < 12; j++) begin
      wr_valid = (wr_sent < 6);
      wr_addr  = 20'(32'h200 + wr_sent);
      wr_data  = 16'(32'hC000 + wr_sent);
      @(negedge clk);
      if (j == 0) begin
        chk("blank_wr_ready_d0", wr_ready, 0);
        chk("tail_disp0", disp_data, base(12'h67E));
      end
      if (j == 1) chk("tail_disp1", disp_data, base(12'h67F));
      if (j == 2) chk("tail_disp_end", disp_valid, 0);
      if (!sram_we_n) begin
        if (first_we < 0) first_we = j;
        last_we = j;
        we_cnt++;
        if (sram_dq !== 16'(32'hC000 + pop_idx) || sram_addr !== 20'(32'h200 + pop_idx) || !sram_dq_oe)
          bad_wd++;
        pop_idx++;
      end
      if (wr_valid && wr_ready) wr_sent++;
      tick();
    end
    wr_valid = 1'b0;
    chk("drain_first_we", first_we, 1);
    chk("drain_last_we", last_we, 6);
    chk("drain_we_count", we_cnt, 6);
    chk("drain_write_order", bad_wd, 0);
    chk("all_writes_taken", wr_sent, 6);

    // reset one cycle after a display request (and a queued write)
    disp_req = 1'b1; disp_addr = 20'h010;
    wr_valid = 1'b1; wr_addr = 20'h300; wr_data = 16'hDEAD;
    tick();
    disp_req = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_disp_valid", disp_valid, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bad_rst = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (disp_valid || rd_rvalid || !sram_we_n) bad_rst++;
    end
    chk("midrst_no_pulse", bad_rst, 0);
    chk("midrst_wr_ready_after", wr_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
